// File: rtl/demux_two_stream.sv
// Two-way stream demultiplexer: words tagged by `select` are steered into one
// of two independent FIFOs, each drained through its own valid/ready handshake.

module demux_two_stream_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = out_valid && pop_ready;
  assign count     = count_q;

  // An empty FIFO presents zero rather than whatever stale word sits at the head.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module demux_two_stream #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [CW-1:0]    a_count,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CW-1:0]    b_count
);

  logic a_full, b_full;
  logic a_push, b_push;
  logic in_fire;

  // Acceptance looks only at the destination's fullness, never at its consumer.
  assign in_ready = !reset && (select ? !b_full : !a_full);
  assign in_fire  = in_valid && in_ready;
  assign a_push   = in_fire && !select;
  assign b_push   = in_fire && select;

  demux_two_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (a_push),
    .push_data (in_data),
    .pop_ready (a_ready),
    .out_valid (a_valid),
    .out_data  (a_data),
    .count     (a_count),
    .full      (a_full)
  );

  demux_two_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (b_push),
    .push_data (in_data),
    .pop_ready (b_ready),
    .out_valid (b_valid),
    .out_data  (b_data),
    .count     (b_count),
    .full      (b_full)
  );

endmodule

// File: tb/tb_demux_two_stream.sv
// Randomized and directed bench for demux_two_stream, checked against a
// queue-based model of the two channel FIFOs.

module tb_demux_two_stream;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             select;
  logic             a_valid, a_ready;
  logic [WIDTH-1:0] a_data;
  logic [CW-1:0]    a_count;
  logic             b_valid, b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CW-1:0]    b_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  demux_two_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .select   (select),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_count  (a_count),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle, compare every output with the model, then advance both.
  task automatic applyStimulus(input logic rst, input logic iv, input logic sel,
                               input logic [WIDTH-1:0] d, input logic ar,
                               input logic br, output logic accepted);
    logic exp_ready, pop_a, pop_b;
    reset    = rst;
    in_valid = iv;
    select   = sel;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #2;
    exp_ready = !rst && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("a_valid",  32'(a_valid),  32'(qa.size() != 0));
    checkOutput("a_data",   32'(a_data),   (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
    checkOutput("a_count",  32'(a_count),  32'(qa.size()));
    checkOutput("b_valid",  32'(b_valid),  32'(qb.size() != 0));
    checkOutput("b_data",   32'(b_data),   (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
    checkOutput("b_count",  32'(b_count),  32'(qb.size()));
    accepted = iv && exp_ready;
    pop_a    = (qa.size() != 0) && ar;
    pop_b    = (qb.size() != 0) && br;
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (pop_b) void'(qb.pop_front());
      if (accepted) begin
        if (sel) qb.push_back(d);
        else     qa.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    logic acc;
    int idx;
    int guard;

    reset = 1'b1; in_valid = 1'b0; select = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 4'($urandom),
                    1'($urandom), 1'($urandom), acc);

    $display("[TB] routing and latency");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1, acc);
    checkOutput("first_accept", 32'(acc), 32'd1);
    checkOutput("a_data_lat", 32'(a_data), 32'hA);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, acc);
    checkOutput("a_valid_once", 32'(a_valid), 32'd0);
    checkOutput("b_data_lat", 32'(b_data), 32'h5);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
    checkOutput("b_valid_once", 32'(b_valid), 32'd0);

    $display("[TB] full boundary");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 1'b1, acc);
    checkOutput("a_count_full", 32'(a_count), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, acc);
    checkOutput("word3_refused", 32'(acc), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, acc);
    checkOutput("full_pop_refused", 32'(acc), 32'd0);
    checkOutput("full_pop_count", 32'(a_count), 32'd1);
    checkOutput("order_2", 32'(a_data), 32'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, acc);
    checkOutput("word3_accepted", 32'(acc), 32'd1);
    checkOutput("order_3", 32'(a_data), 32'h3);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);

    $display("[TB] independence");
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, acc);
    checkOutput("b_full_count", 32'(b_count), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, acc);
    checkOutput("a_push_indep", 32'(acc), 32'd1);
    checkOutput("a_count_indep", 32'(a_count), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 1'b0, acc);
    checkOutput("b_full_refused", 32'(acc), 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);

    $display("[TB] wrap-around on B");
    idx = 0;
    guard = 0;
    while (idx < 10 && guard < 100) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'(idx), 1'(guard), 1'(guard), acc);
      if (acc) idx++;
      guard++;
    end
    checkOutput("stream_done", 32'(idx), 32'd10);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0, acc);
    checkOutput("one_buffered", 32'(b_count), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    checkOutput("reset_b_valid", 32'(b_valid), 32'd0);
    checkOutput("reset_b_count", 32'(b_count), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++)
      applyStimulus(($urandom_range(63) == 0), 1'($urandom), 1'($urandom),
                    4'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) == 0), acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_two_stream.md
# demux_two_stream

Two-way stream demultiplexer, the receiving-side counterpart of the 2:1 mux. A single input stream carries words tagged with a `select` bit. The block steers each accepted word to output channel A (`select`=0) or channel B (`select`=1). Each channel has its own FIFO and a valid/ready handshake, so a stalled channel does not lose data or reorder it.

## Interface

- `WIDTH`, 1: data width in bits. Benches instantiate with 4.
- `DEPTH`, 2: entries per channel FIFO. Must be a power of 2 and ≥2.
- `CW`, log2(`DEPTH`)+1: occupancy counter width. Derived, not overridden.

- `clk`  in  1: sole clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. Sampled on the `clk` rising edge.
- `in_valid`  in  1: input word present.
- `in_ready`  out  1: input word accepted this cycle if `in_valid` is also high.
- `in_data`  in  `WIDTH`: input word.
- `select`  in  1: destination. 0 means channel A, 1 means channel B. Qualified by `in_valid`.
- `a_valid`  out  1: channel A head word available.
- `a_ready`  in  1: downstream consumes the A head word.
- `a_data`  out  `WIDTH`: channel A head word.
- `a_count`  out  `CW`: channel A occupancy, 0..`DEPTH`.
- `b_valid`, `b_ready`, `b_data`, `b_count`: same as the A signals, for channel B.

## Operation

- Push rule:
  - An input transfer happens when `in_valid` && `in_ready`.
  - The word is written to the FIFO named by `select`.
  - The other FIFO is untouched.
- `in_ready` is combinational:
  - It equals !full(A) when `select`=0, and !full(B) when `select`=1.
  - It is forced to 0 while `reset` is high.
- Pop rule: channel X pops when `X_valid` && `X_ready`. `X_valid` = (`X_count` != 0).
- `X_data` is the head entry, driven from registered storage. It is 0 when the FIFO is empty.
- Each FIFO uses read/write pointers of log2(`DEPTH`) bits. Pointers wrap from `DEPTH`-1 to 0.
- Count update per cycle: `X_count` += push − pop.
- Full FIFO with a simultaneous pop:
  - The push is still refused; `in_ready` does not depend on `X_ready`.
  - The pop proceeds and the count decrements.
- Empty FIFO: pop is impossible because valid is low, so `X_ready` is ignored.
- Simultaneous push and pop on the same non-empty, non-full channel: both occur and the count is unchanged.
- Channels are independent. A push to A and a pop from B in the same cycle both take effect.
- Per-channel order is preserved (FIFO). There is no ordering relation between channels.
- When `in_valid`=0, `select` and `in_data` are don't-care and cause no state change.

## Timing

- Reset values, one edge after `reset` is asserted:
  - `a_valid`=`b_valid`=0, `a_data`=`b_data`=0, `a_count`=`b_count`=0.
  - Pointers are 0.
  - FIFO contents are don't-care.
- Reset mid-operation discards all buffered words in both channels on that edge.
- First accept after reset:
  - `in_ready`=1 in the first cycle with `reset` low.
  - A word can be accepted in that cycle.
- Latency: a word accepted at edge N appears at `X_data` with `X_valid`=1 in the cycle after edge N. That is 1 cycle into an empty FIFO.
- Throughput: 1 word per cycle when the destination is not full.
- Sustained full rate per channel needs the consumer to pop every cycle.
- Back-pressure:
  - With `DEPTH`=2 and `X_ready`=0, a third consecutive word to channel X sees `in_ready`=0.
  - That word must be held stable by the source until accepted.
  - While held, the source must not change `select` for that word.

## Test plan

- Reset: drive random inputs with `reset`=1 for 3 cycles. Expect all valid=0, data=0, counts=0 and `in_ready`=0. Release reset: `in_ready`=1.
- Routing and latency:
  - Push 4'hA with `select`=0, then 4'h5 with `select`=1, all readies=1.
  - Expect `a_data`=4'hA one cycle after its push, and `b_data`=4'h5 one cycle after its push.
  - Each word is valid for exactly 1 cycle.
  - The other channel's valid stays 0.
- Full boundary:
  - Hold `a_ready`=0 and push 1, 2, 3 to A.
  - Expect `a_count`=2 and `in_ready`=0 for word 3.
  - Raise `a_ready`: pop 1, then word 3 is accepted the cycle after.
  - Output order is 1, 2, 3.
- Full plus pop: A holds 2 words; present a push to A and `a_ready`=1 in the same cycle. Expect the push refused and `a_count` 2→1.
- Independence:
  - B is full with `b_ready`=0.
  - Push 4'h7 to A while `in_valid` stays high.
  - Expect the A push accepted and `a_count`=1.
  - Switching to `select`=1 then gives `in_ready`=0.
- Wrap-around and reset mid-stream:
  - Stream 0..9 through B with `b_ready` toggling each cycle, so the pointers wrap several times.
  - Check in-order output.
  - Assert `reset` with 1 word buffered: next cycle `b_valid`=0 and `b_count`=0.
